algofoogle_mac: RTL and testbench



---
 rtl/algofoogle_mac.sv | 131 +++++++++++++
 tb/tb_algofoogle_mac.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/algofoogle_mac.sv
// Nibble-serial OPW x OPW multiplier / MAC with byte-wise accumulator readout.
// Result lands OPW cycles after the last B nibble; no backpressure, strobes are edge-detected levels.
module algofoogle_mac #(
    parameter int OPW  = 8,
    parameter int ACCW = 24
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       read,
    input  logic [3:0] nibble,
    input  logic       mode,
    input  logic       out_next,
    input  logic       acc_clr,
    output logic [7:0] result,
    output logic       busy,
    output logic       done
);

    localparam int NN  = OPW / 4;
    localparam int NB  = ACCW / 8;
    localparam int PW  = 2 * OPW;
    localparam int NCW = (NN > 1) ? $clog2(NN) : 1;
    localparam int BCW = $clog2(OPW);
    localparam int BIW = (NB > 1) ? $clog2(NB) : 1;

    typedef enum logic [1:0] {LOAD_A, LOAD_B, CALC, SHOW} state_t;

    state_t          state_q;
    logic            read_q, next_q, mode_q;
    logic [OPW-1:0]  a_q, b_q;
    logic [PW-1:0]   prod_q;
    logic [ACCW-1:0] acc_q;
    logic [NCW-1:0]  nib_cnt_q;
    logic [BCW-1:0]  bit_cnt_q;
    logic [BIW-1:0]  byte_idx_q;

    logic            rd_edge, nx_edge, last_nib;
    logic [OPW-1:0]  a_shift, b_shift;
    logic [PW-1:0]   pp, prod_d;
    logic [ACCW-1:0] acc_d;

    assign rd_edge  = read & ~read_q;
    assign nx_edge  = out_next & ~next_q;
    assign last_nib = (nib_cnt_q == NCW'(NN - 1));
    assign a_shift  = (a_q << 4) | OPW'(nibble);
    assign b_shift  = (b_q << 4) | OPW'(nibble);

    // prod_d includes the current bit so the final edge commits the full product.
    assign pp     = b_q[bit_cnt_q] ? (PW'(a_q) << bit_cnt_q) : '0;
    assign prod_d = prod_q + pp;
    assign acc_d  = mode_q ? (acc_q + ACCW'(prod_d)) : ACCW'(prod_d);

    assign result = acc_q[8*byte_idx_q +: 8];
    assign busy   = (state_q == CALC);
    assign done   = (state_q == SHOW);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= LOAD_A;
            read_q     <= 1'b1;
            next_q     <= 1'b1;
            mode_q     <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            prod_q     <= '0;
            acc_q      <= '0;
            nib_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            byte_idx_q <= '0;
        end else begin
            read_q <= read;
            next_q <= out_next;
            case (state_q)
                LOAD_A: begin
                    if (rd_edge) begin
                        a_q <= a_shift;
                        if (last_nib) begin
                            nib_cnt_q <= '0;
                            state_q   <= LOAD_B;
                        end else begin
                            nib_cnt_q <= nib_cnt_q + 1'b1;
                        end
                    end
                end
                LOAD_B: begin
                    if (rd_edge) begin
                        b_q <= b_shift;
                        if (last_nib) begin
                            nib_cnt_q <= '0;
                            mode_q    <= mode;
                            prod_q    <= '0;
                            bit_cnt_q <= '0;
                            state_q   <= CALC;
                        end else begin
                            nib_cnt_q <= nib_cnt_q + 1'b1;
                        end
                    end
                end
                CALC: begin
                    prod_q <= prod_d;
                    if (bit_cnt_q == BCW'(OPW - 1)) begin
                        acc_q      <= acc_d;
                        byte_idx_q <= '0;
                        state_q    <= SHOW;
                    end else begin
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                    end
                end
                SHOW: begin
                    if (nx_edge)
                        byte_idx_q <= (byte_idx_q == BIW'(NB - 1)) ? '0 : byte_idx_q + 1'b1;
                    // A read edge here is already the first nibble of the next A operand.
                    if (rd_edge) begin
                        a_q <= OPW'(nibble);
                        if (NN == 1) begin
                            nib_cnt_q <= '0;
                            state_q   <= LOAD_B;
                        end else begin
                            nib_cnt_q <= NCW'(1);
                            state_q   <= LOAD_A;
                        end
                    end
                end
                default: state_q <= LOAD_A;
            endcase
            if (acc_clr)
                acc_q <= '0;
        end
    end

endmodule

// File: tb/tb_algofoogle_mac.sv
// Scoreboard bench driving three parameterisations of algofoogle_mac one at a time.
module tb_algofoogle_mac;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] nibble;
    logic       mode;
    logic [2:0] rd_v, nx_v, clr_v;
    logic [2:0] busy_v, done_v;
    logic [7:0] res0, res1, res2, res_s;

    always #5 clk = ~clk;

    algofoogle_mac #(.OPW(8), .ACCW(24)) u0 (
        .clk(clk), .reset_n(reset_n), .read(rd_v[0]), .nibble(nibble), .mode(mode),
        .out_next(nx_v[0]), .acc_clr(clr_v[0]), .result(res0), .busy(busy_v[0]), .done(done_v[0]));
    algofoogle_mac #(.OPW(8), .ACCW(16)) u1 (
        .clk(clk), .reset_n(reset_n), .read(rd_v[1]), .nibble(nibble), .mode(mode),
        .out_next(nx_v[1]), .acc_clr(clr_v[1]), .result(res1), .busy(busy_v[1]), .done(done_v[1]));
    algofoogle_mac #(.OPW(4), .ACCW(8)) u2 (
        .clk(clk), .reset_n(reset_n), .read(rd_v[2]), .nibble(nibble), .mode(mode),
        .out_next(nx_v[2]), .acc_clr(clr_v[2]), .result(res2), .busy(busy_v[2]), .done(done_v[2]));

    int          sel = 0;
    int          opw_t [3] = '{8, 8, 4};
    int          accw_t[3] = '{24, 16, 8};
    logic [31:0] exp_acc[3];
    logic [31:0] exp_q[$];
    int          errs = 0;
    int          checks = 0;
    int          bcnt = 0;

    always_comb begin
        case (sel)
            0:       res_s = res0;
            1:       res_s = res1;
            default: res_s = res2;
        endcase
    end

    always @(negedge clk) if (busy_v[sel]) bcnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_nib(input logic [3:0] n, input int hold);
        nibble    = n;
        rd_v[sel] = 1'b1;
        repeat (hold) tick();
        rd_v[sel] = 1'b0;
        tick();
    endtask

    task automatic load_ops(input logic [31:0] a, input logic [31:0] b, input logic m, input int hold);
        int nn;
        nn   = opw_t[sel] / 4;
        mode = m;
        bcnt = 0;
        for (int i = nn - 1; i >= 0; i--) send_nib(a[4*i +: 4], hold);
        for (int i = nn - 1; i >= 0; i--) send_nib(b[4*i +: 4], hold);
    endtask

    task automatic push_exp(input logic [31:0] a, input logic [31:0] b, input logic m);
        logic [31:0] mask;
        mask = (32'd1 << accw_t[sel]) - 32'd1;
        exp_acc[sel] = (m ? exp_acc[sel] + a * b : a * b) & mask;
        exp_q.push_back(exp_acc[sel]);
    endtask

    task automatic read_bytes(input string tag, input logic [31:0] exp);
        int nb, k;
        nb = accw_t[sel] / 8;
        check({tag, ".byte0"}, {24'd0, res_s}, exp & 32'hFF);
        for (int i = 1; i <= nb; i++) begin
            nx_v[sel] = 1'b1;
            tick();
            nx_v[sel] = 1'b0;
            tick();
            k = i % nb;
            check($sformatf("%s.byte%0d_%0d", tag, i, k), {24'd0, res_s}, (exp >> (8 * k)) & 32'hFF);
        end
    endtask

    task automatic wait_result(input string tag);
        int t;
        logic [31:0] exp;
        t = 0;
        while (!done_v[sel] && t < 200) begin
            tick();
            t++;
        end
        check({tag, ".done"}, {31'd0, done_v[sel]}, 32'd1);
        check({tag, ".busy_cycles"}, bcnt, opw_t[sel]);
        if (exp_q.size() == 0) begin
            check({tag, ".scoreboard_empty"}, 32'd1, 32'd0);
        end else begin
            exp = exp_q.pop_front();
            read_bytes(tag, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic m, input int hold);
        push_exp(a, b, m);
        load_ops(a, b, m, hold);
        wait_result(tag);
    endtask

    initial begin
        reset_n = 1'b0;
        rd_v = '0; nx_v = '0; clr_v = '0;
        nibble = '0; mode = 1'b0;
        for (int i = 0; i < 3; i++) exp_acc[i] = '0;
        repeat (3) tick();
        check("rst.res0", {24'd0, res0}, 32'd0);
        check("rst.res1", {24'd0, res1}, 32'd0);
        check("rst.res2", {24'd0, res2}, 32'd0);
        check("rst.busy", {29'd0, busy_v}, 32'd0);
        check("rst.done", {29'd0, done_v}, 32'd0);
        reset_n = 1'b1;
        tick();

        // 8x8 into 24-bit accumulator
        sel = 0;
        run_op("t1_ffxff", 32'hFF, 32'hFF, 1'b0, 1);
        run_op("t2_mac1", 32'h12, 32'h34, 1'b1, 1);
        run_op("t2_mac2", 32'h12, 32'h34, 1'b1, 1);
        run_op("t2_mul", 32'h02, 32'h03, 1'b0, 1);

        run_op("t3_hold5", 32'hA5, 32'h3C, 1'b1, 5);
        push_exp(32'h7E, 32'h9B, 1'b0);
        load_ops(32'h7E, 32'h9B, 1'b0, 1);
        mode = 1'b1;
        send_nib(4'hF, 1);
        send_nib(4'h1, 1);
        mode = 1'b0;
        wait_result("t3_calc_noise");

        // reset in the middle of CALC with read held high across release
        load_ops(32'h55, 32'h33, 1'b0, 1);
        nibble  = 4'hF;
        rd_v[0] = 1'b1;
        tick();
        tick();
        reset_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) exp_acc[i] = '0;
        check("t4_rst.res", {24'd0, res0}, 32'd0);
        check("t4_rst.busy", {31'd0, busy_v[0]}, 32'd0);
        check("t4_rst.done", {31'd0, done_v[0]}, 32'd0);
        tick();
        tick();
        reset_n = 1'b1;
        repeat (3) tick();
        check("t4_rel.res", {24'd0, res0}, 32'd0);
        check("t4_rel.busy", {31'd0, busy_v[0]}, 32'd0);
        check("t4_rel.done", {31'd0, done_v[0]}, 32'd0);
        rd_v[0] = 1'b0;
        tick();
        run_op("t4_after", 32'h02, 32'h03, 1'b0, 1);

        // 8x8 into 16-bit accumulator: wrap and clear
        sel = 1;
        run_op("t5_mac1", 32'hFF, 32'hFF, 1'b1, 1);
        run_op("t5_mac2", 32'hFF, 32'hFF, 1'b1, 1);
        clr_v[1] = 1'b1;
        tick();
        clr_v[1] = 1'b0;
        exp_acc[1] = '0;
        check("t5_clr.res", {24'd0, res_s}, 32'd0);
        check("t5_clr.done", {31'd0, done_v[1]}, 32'd1);

        // 4x4 into 8-bit accumulator; SHOW read edge loads A and heads for LOAD_B
        sel = 2;
        run_op("t6_mul", 32'hD, 32'hB, 1'b0, 1);
        push_exp(32'h3, 32'h5, 1'b1);
        mode = 1'b1;
        bcnt = 0;
        send_nib(4'h3, 1);
        check("t6_show_rd.busy", {31'd0, busy_v[2]}, 32'd0);
        check("t6_show_rd.done", {31'd0, done_v[2]}, 32'd0);
        send_nib(4'h5, 1);
        wait_result("t6_mac");

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
